dmem_mmio_bridge: RTL and testbench

//  Sits between the processor's dmem port and the dmem syncram, downstream of the processor.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/mmio_tx_fifo.sv | 83 ++++++++
 rtl/dmem_mmio_bridge.sv | 139 +++++++++++++
 tb/tb_dmem_mmio_bridge.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// ----------------------------------------------------------------------------
// mmio_pkg
// Shared constants and helpers for the dmem MMIO bridge.
//   - Register offsets inside the MMIO page (relative to IO_BASE).
//   - Bit positions of the fields in the STATUS word.
//   - is_mmio(): region decode; any address at or above the base is MMIO.
// Optional feature macro used by the bridge: CYCLE_COUNTER_EN.
// ----------------------------------------------------------------------------
package mmio_pkg;

    // Register offsets from IO_BASE
    localparam int OFF_TXDATA = 0;
    localparam int OFF_STATUS = 1;
    localparam int OFF_LED    = 2;
    localparam int OFF_CYCLES = 3;

    // STATUS word layout
    localparam int STS_FULL    = 0;
    localparam int STS_EMPTY   = 1;
    localparam int STS_OVF     = 2;
    localparam int STS_CNT_LSB = 4;
    localparam int STS_CNT_W   = 5;

    // Callers zero-extend their address and base to 32 bits
    function automatic logic is_mmio(input logic [31:0] addr, input logic [31:0] base);
        return (addr >= base);
    endfunction

endpackage

// File: rtl/mmio_tx_fifo.sv
// ----------------------------------------------------------------------------
// mmio_tx_fifo
// Byte transmit FIFO behind the TXDATA register. No fall-through: a byte
// pushed into an empty FIFO shows on dout the cycle after the push.
// Ports:
//   clock, reset        clock; asynchronous active-low reset (empties FIFO)
//   push, din           push request and byte
//   full                FIFO holds DEPTH entries
//   overflow_push       push refused this cycle (full and no pop); byte dropped
//   pop                 consumer accepts the head (ignored while empty)
//   dout                head byte, forced 0 while empty
//   empty               FIFO holds no entries
//   count               occupancy 0..DEPTH
// ----------------------------------------------------------------------------
module mmio_tx_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     din,
    output logic             full,
    output logic             overflow_push,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    assign pop_ok        = pop & ~empty;
    // A pop on the same edge frees a slot, so a push at full still succeeds.
    assign push_ok       = push & (~full | pop_ok);
    assign overflow_push = push & full & ~pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth: pointers wrap by plain overflow.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; dout is masked while empty instead.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// ----------------------------------------------------------------------------
// dmem_mmio_bridge
// Splits the processor dmem port into the RAM region (passed to the dmem
// syncram) and a top MMIO page holding TXDATA, STATUS, LED and CYCLES.
// Ports:
//   clock, reset                 clock; asynchronous active-low reset
//   p_address/p_data/p_wren/p_q  processor side
//   m_address/m_data/m_wren/m_q  dmem side; m_wren only for RAM writes
//   tx_data/tx_valid/tx_ready    byte stream out of the TX FIFO
//   led                          LED register
// Optional feature: define CYCLE_COUNTER_EN to add a 32-bit free-running
// cycle counter at offset +3 (loadable by writes). Without it +3 reads 0.
// ----------------------------------------------------------------------------
module dmem_mmio_bridge
    import mmio_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] IO_BASE    = 12'hF00,
    parameter int                FIFO_DEPTH = 8,
    parameter int                LED_W      = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] p_address,
    input  logic [DATA_W-1:0] p_data,
    input  logic              p_wren,
    output logic [DATA_W-1:0] p_q,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data,
    output logic              m_wren,
    input  logic [DATA_W-1:0] m_q,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [LED_W-1:0]  led
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              mmio;
    logic [ADDR_W-1:0] offset;
    logic              sel_tx, sel_sts, sel_led, sel_cyc;
    logic [DATA_W-1:0] mmio_rdata;
    logic [DATA_W-1:0] status;
    logic [DATA_W-1:0] cyc_rd;

    logic              fifo_full, fifo_empty, fifo_ovf_push;
    logic [CNT_W-1:0]  fifo_count;

    logic [LED_W-1:0]  led_q, led_d;
    logic              ovf_q, ovf_d;

    assign mmio   = is_mmio(32'(p_address), 32'(IO_BASE));
    assign offset = p_address - IO_BASE;
    assign sel_tx  = mmio && (offset == ADDR_W'(OFF_TXDATA));
    assign sel_sts = mmio && (offset == ADDR_W'(OFF_STATUS));
    assign sel_led = mmio && (offset == ADDR_W'(OFF_LED));
    assign sel_cyc = mmio && (offset == ADDR_W'(OFF_CYCLES));

    // dmem pass-through; writes are gated off for MMIO and while in reset.
    assign m_address = p_address;
    assign m_data    = p_data;
    assign m_wren    = p_wren & ~mmio & reset;

    mmio_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (p_wren & sel_tx),
        .din           (p_data[7:0]),
        .full          (fifo_full),
        .overflow_push (fifo_ovf_push),
        .pop           (tx_ready),
        .dout          (tx_data),
        .empty         (fifo_empty),
        .count         (fifo_count)
    );

    assign tx_valid = ~fifo_empty;
    assign led      = led_q;

    always_comb begin
        status                               = '0;
        status[STS_FULL]                     = fifo_full;
        status[STS_EMPTY]                    = fifo_empty;
        status[STS_OVF]                      = ovf_q;
        status[STS_CNT_LSB +: STS_CNT_W]     = STS_CNT_W'(fifo_count);
    end

    always_comb begin
        mmio_rdata = '0;
        if (sel_sts)      mmio_rdata = status;
        else if (sel_led) mmio_rdata = DATA_W'(led_q);
        else if (sel_cyc) mmio_rdata = cyc_rd;
    end

    assign p_q = mmio ? mmio_rdata : m_q;

    always_comb begin
        led_d = led_q;
        ovf_d = ovf_q;
        if (p_wren && sel_led) led_d = p_data[LED_W-1:0];
        if (p_wren && sel_sts) ovf_d = 1'b0;
        // A dropped byte on the same edge as a STATUS clear keeps the flag set.
        if (fifo_ovf_push)     ovf_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            led_q <= led_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (p_wren && sel_cyc) cyc_d = p_data[31:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cyc_q <= '0;
        else        cyc_q <= cyc_d;
    end

    assign cyc_rd = DATA_W'(cyc_q);
`else
    assign cyc_rd = '0;
`endif

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// ----------------------------------------------------------------------------
// tb_dmem_mmio_bridge
// Directed-vector bench for dmem_mmio_bridge with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_dmem_mmio_bridge;

    logic        clock;
    logic        reset;
    logic [11:0] p_address;
    logic [31:0] p_data;
    logic        p_wren;
    logic [31:0] p_q;
    logic [11:0] m_address;
    logic [31:0] m_data;
    logic        m_wren;
    logic [31:0] m_q;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  led;

    int n_vec;
    int n_err;

    dmem_mmio_bridge dut (
        .clock     (clock),
        .reset     (reset),
        .p_address (p_address),
        .p_data    (p_data),
        .p_wren    (p_wren),
        .p_q       (p_q),
        .m_address (m_address),
        .m_data    (m_data),
        .m_wren    (m_wren),
        .m_q       (m_q),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .led       (led)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        p_address = a;
        p_data    = d;
        p_wren    = 1'b1;
        tick();
        p_wren    = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        p_address = a;
        p_wren    = 1'b0;
        #1;
        check(tag, p_q, exp);
    endtask

    logic [7:0] drain_exp [8];

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        p_address = '0;
        p_data    = '0;
        p_wren    = 1'b0;
        m_q       = 32'h0;
        tx_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'b0, tx_data}, 32'h0);
        check("rst_led", {24'b0, led}, 32'h0);
        tick();
        reset = 1'b1;
        tick();

        // RAM region write/read pass-through
        p_address = 12'h100;
        p_data    = 32'h55;
        p_wren    = 1'b1;
        #1;
        check("ram_m_wren", {31'b0, m_wren}, 32'h1);
        check("ram_m_address", {20'b0, m_address}, 32'h100);
        check("ram_m_data", m_data, 32'h55);
        tick();
        p_wren = 1'b0;
        m_q    = 32'hCAFEF00D;
        rd_check("ram_read", 12'h100, 32'hCAFEF00D);

        // LED write never reaches dmem
        p_address = 12'hF02;
        p_data    = 32'h000000A5;
        p_wren    = 1'b1;
        #1;
        check("mmio_m_wren", {31'b0, m_wren}, 32'h0);
        check("led_before_edge", {24'b0, led}, 32'h0);
        tick();
        p_wren = 1'b0;
        check("led_after", {24'b0, led}, 32'hA5);
        rd_check("led_read", 12'hF02, 32'h000000A5);

        // Unmapped offset: write ignored, read 0; LED untouched
        wr(12'hF05, 32'h77);
        rd_check("unmapped_read", 12'hF05, 32'h0);
        rd_check("led_unchanged", 12'hF02, 32'h000000A5);

        // FIFO push, no fall-through
        p_address = 12'hF00;
        p_data    = 32'h41;
        p_wren    = 1'b1;
        #1;
        check("no_fallthrough", {31'b0, tx_valid}, 32'h0);
        tick();
        check("valid_after_push", {31'b0, tx_valid}, 32'h1);
        wr(12'hF00, 32'h42);
        wr(12'hF00, 32'h43);
        check("head_41", {24'b0, tx_data}, 32'h41);
        rd_check("status_cnt3", 12'hF01, 32'h030);
        rd_check("txdata_reads0", 12'hF00, 32'h0);
        tick();
        check("head_hold", {24'b0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        #1;
        check("pop0", {24'b0, tx_data}, 32'h41);
        tick();
        check("pop1", {24'b0, tx_data}, 32'h42);
        tick();
        check("pop2", {24'b0, tx_data}, 32'h43);
        tick();
        check("drained_valid", {31'b0, tx_valid}, 32'h0);
        rd_check("drained_status", 12'hF01, 32'h002);
        tx_ready = 1'b0;

        // Asynchronous reset with 3 bytes queued
        wr(12'hF00, 32'h61);
        wr(12'hF00, 32'h62);
        wr(12'hF00, 32'h63);
        check("pre_reset_valid", {31'b0, tx_valid}, 32'h1);
        p_address = 12'hF01;
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", {31'b0, tx_valid}, 32'h0);
        check("areset_led", {24'b0, led}, 32'h0);
        check("areset_status", p_q, 32'h002);
        p_address = 12'h200;
        p_wren    = 1'b1;
        #1;
        check("areset_m_wren", {31'b0, m_wren}, 32'h0);
        p_wren = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Overflow: 9 pushes into 8 entries
        for (int i = 0; i < 8; i++) wr(12'hF00, 32'h10 + 32'(i));
        rd_check("full_status", 12'hF01, 32'h081);
        wr(12'hF00, 32'h18);
        rd_check("ovf_status", 12'hF01, 32'h085);
        check("ovf_head", {24'b0, tx_data}, 32'h10);
        wr(12'hF01, 32'h0);
        rd_check("ovf_cleared", 12'hF01, 32'h081);

        // Push and pop together at full
        tx_ready = 1'b1;
        wr(12'hF00, 32'h99);
        tx_ready = 1'b0;
        rd_check("pushpop_full", 12'hF01, 32'h081);

        // Drain: 0x10 popped, 0x18 was dropped, 0x99 landed last
        for (int i = 0; i < 7; i++) drain_exp[i] = 8'h11 + 8'(i);
        drain_exp[7] = 8'h99;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("drain%0d", i), {24'b0, tx_data}, {24'b0, drain_exp[i]});
            tick();
        end
        tx_ready = 1'b0;
        check("drain_empty", {31'b0, tx_valid}, 32'h0);

`ifdef CYCLE_COUNTER_EN
        wr(12'hF03, 32'hFFFFFFFE);
        rd_check("cyc_loaded", 12'hF03, 32'hFFFFFFFE);
        tick();
        check("cyc_ffffffff", p_q, 32'hFFFFFFFF);
        tick();
        check("cyc_wrap", p_q, 32'h0);
`else
        wr(12'hF03, 32'h12345678);
        rd_check("cyc_absent", 12'hF03, 32'h0);
        tick();
        check("cyc_absent2", p_q, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
